multicycle_control_unit: RTL and testbench

//   Multi-cycle RV32I control FSM. Fetches each instruction over a req/ready handshake and decodes it.

---
 rtl/multicycle_control_unit_if.sv | 29 ++
 rtl/multicycle_control_unit.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multi-cycle controller and the instruction/data memories.
//   imem_req   : instruction fetch request (controller -> memory)
//   imem_ready : fetch complete, instruction valid this cycle (memory -> controller)
//   dmem_req   : data access request (controller -> memory)
//   dmem_we    : 1 = store, 0 = load; qualified by dmem_req (controller -> memory)
//   dmem_ready : data access complete (memory -> controller)
interface multicycle_control_unit_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        input  imem_ready,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM. Fetches each instruction over the imem handshake, decodes
// the opcode and sequences operand, PC, memory and writeback controls for the datapath.
// Ports:
//   clock, reset       : system clock; synchronous active-high reset
//   instruction        : instruction register contents (latched by datapath on ir_write)
//   branch_taken       : comparator result for the current branch
//   mem                : imem/dmem request/ready handshake (master side)
//   ir_write           : latch instruction register
//   immediate_select   : 001 I, 010 S, 011 B, 100 U, 101 J, 000 none
//   alu_src_a_pc       : ALU operand A = PC
//   alu_src_b_imm      : ALU operand B = immediate
//   reg_write          : register file write pulse
//   wb_select          : 00 ALU, 01 load data, 10 PC+4
//   pc_write, pc_select: PC update strobe; 0 = PC+4, 1 = ALU target
//   trap               : sticky illegal-opcode / memory-timeout flag
module multicycle_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [31:0]                       instruction,
    input  logic                              branch_taken,
    multicycle_control_unit_if.master         mem,
    output logic                              ir_write,
    output logic [2:0]                        immediate_select,
    output logic                              alu_src_a_pc,
    output logic                              alu_src_b_imm,
    output logic                              reg_write,
    output logic [1:0]                        wb_select,
    output logic                              pc_write,
    output logic                              pc_select,
    output logic                              trap
);

    localparam logic [15:0] LastWait = 16'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StTrap
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Opcode classes
    logic [6:0] opcode;
    logic [4:0] rd;
    logic       is_load, is_store, is_branch, is_jal, is_jalr;
    logic       is_lui, is_auipc, is_op_imm, is_op, is_nop, is_legal;
    logic [2:0] imm_sel_dec;
    logic       unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign rd                = instruction[11:7];
    assign unused_instr_bits = ^instruction[31:12];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_op_imm = 1'b0;
        is_op     = 1'b0;
        is_nop    = 1'b0;
        unique case (opcode)
            7'b0000011: is_load   = 1'b1;
            7'b0100011: is_store  = 1'b1;
            7'b1100011: is_branch = 1'b1;
            7'b1101111: is_jal    = 1'b1;
            7'b1100111: is_jalr   = 1'b1;
            7'b0110111: is_lui    = 1'b1;
            7'b0010111: is_auipc  = 1'b1;
            7'b0010011: is_op_imm = 1'b1;
            7'b0110011: is_op     = 1'b1;
            7'b0001111,                       // FENCE
            7'b1110011: is_nop    = 1'b1;     // SYSTEM
            default: ;
        endcase
    end

    assign is_legal = is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc
                    | is_op_imm | is_op | is_nop;

    always_comb begin
        imm_sel_dec = 3'b000;
        if (is_op_imm || is_load || is_jalr) imm_sel_dec = 3'b001;
        else if (is_store)                   imm_sel_dec = 3'b010;
        else if (is_branch)                  imm_sel_dec = 3'b011;
        else if (is_lui || is_auipc)         imm_sel_dec = 3'b100;
        else if (is_jal)                     imm_sel_dec = 3'b101;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state; wait counter only runs while a memory request is outstanding
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            StFetch: begin
                if (mem.imem_ready)             state_d = StDecode;
                else if (wait_cnt_q == LastWait) state_d = StTrap;
                else                            wait_cnt_d = wait_cnt_q + 16'd1;
            end
            StDecode: begin
                if (!is_legal)   state_d = StTrap;
                else if (is_nop) state_d = StFetch;
                else             state_d = StExecute;
            end
            StExecute: begin
                if (is_branch)                 state_d = StFetch;
                else if (is_load || is_store) state_d = StMemory;
                else                           state_d = StWriteback;
            end
            StMemory: begin
                if (mem.dmem_ready)              state_d = is_store ? StFetch : StWriteback;
                else if (wait_cnt_q == LastWait) state_d = StTrap;
                else                             wait_cnt_d = wait_cnt_q + 16'd1;
            end
            StWriteback: state_d = StFetch;
            StTrap:      state_d = StTrap;
            default:     state_d = StFetch;
        endcase
    end

    // Outputs; everything is held low while reset is asserted
    always_comb begin
        mem.imem_req     = 1'b0;
        mem.dmem_req     = 1'b0;
        mem.dmem_we      = 1'b0;
        ir_write         = 1'b0;
        immediate_select = 3'b000;
        alu_src_a_pc     = 1'b0;
        alu_src_b_imm    = 1'b0;
        reg_write        = 1'b0;
        wb_select        = 2'b00;
        pc_write         = 1'b0;
        pc_select        = 1'b0;
        trap             = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    mem.imem_req = 1'b1;
                    ir_write     = mem.imem_ready;
                end
                StDecode: begin
                    immediate_select = imm_sel_dec;
                    pc_write         = is_nop;
                end
                StExecute: begin
                    immediate_select = imm_sel_dec;
                    // Branch uses the ALU for PC+imm; the compare comes in on branch_taken
                    alu_src_a_pc     = is_auipc | is_jal | is_branch;
                    alu_src_b_imm    = ~is_op;
                    if (is_branch) begin
                        pc_write  = 1'b1;
                        pc_select = branch_taken;
                    end
                end
                StMemory: begin
                    immediate_select = imm_sel_dec;
                    mem.dmem_req     = 1'b1;
                    mem.dmem_we      = is_store;
                    pc_write         = is_store & mem.dmem_ready;
                end
                StWriteback: begin
                    immediate_select = imm_sel_dec;
                    reg_write        = (rd != 5'd0);
                    pc_write         = 1'b1;
                    pc_select        = is_jal | is_jalr;
                    if (is_load)                wb_select = 2'b01;
                    else if (is_jal || is_jalr) wb_select = 2'b10;
                end
                StTrap:  trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam int unsigned Tmo = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        branch_taken = 1'b0;
    logic        ir_write, alu_src_a_pc, alu_src_b_imm, reg_write, pc_write, pc_select, trap;
    logic [2:0]  immediate_select;
    logic [1:0]  wb_select;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(.MEM_TIMEOUT(Tmo)) dut (
        .clock            (clock),
        .reset            (reset),
        .instruction      (instruction),
        .branch_taken     (branch_taken),
        .mem              (bus.master),
        .ir_write         (ir_write),
        .immediate_select (immediate_select),
        .alu_src_a_pc     (alu_src_a_pc),
        .alu_src_b_imm    (alu_src_b_imm),
        .reg_write        (reg_write),
        .wb_select        (wb_select),
        .pc_write         (pc_write),
        .pc_select        (pc_select),
        .trap             (trap)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       dmem_req;
        logic       dmem_we;
        logic [2:0] imm;
        logic       a_pc;
        logic       b_imm;
        logic       reg_write;
        logic [1:0] wb;
        logic       pc_write;
        logic       pc_sel;
        logic       trap;
    } ctl_t;

    typedef struct packed {
        logic iready;
        logic dready;
    } inp_t;

    ctl_t  seq_o[$];
    inp_t  seq_i[$];
    ctl_t  exp_q[$];
    int    idx_q[$];
    string cur_name = "init";
    int    checks = 0;
    int    errors = 0;

    function automatic void add(input ctl_t c, input logic ir, input logic dr);
        inp_t p;
        p.iready = ir;
        p.dready = dr;
        seq_o.push_back(c);
        seq_i.push_back(p);
    endfunction

    // Trap is sticky: ready pulses are offered and must be ignored
    function automatic void add_trap();
        ctl_t c;
        for (int k = 0; k < 3; k++) begin
            c = '0;
            c.trap = 1'b1;
            add(c, 1'b1, 1'b1);
        end
    endfunction

    // Cycle-by-cycle expected controls for one instruction with fw fetch waits and mw data waits
    function automatic void build(input logic [31:0] ins, input int fw, input int mw,
                                  input logic taken);
        logic [6:0] op;
        logic       ld, st, br, jal, jalr, lui, auipc, opimm, opr, nop, legal;
        logic [2:0] imm;
        ctl_t       c;
        seq_o.delete();
        seq_i.delete();
        op    = ins[6:0];
        ld    = (op == 7'h03);
        st    = (op == 7'h23);
        br    = (op == 7'h63);
        jal   = (op == 7'h6F);
        jalr  = (op == 7'h67);
        lui   = (op == 7'h37);
        auipc = (op == 7'h17);
        opimm = (op == 7'h13);
        opr   = (op == 7'h33);
        nop   = (op == 7'h0F) || (op == 7'h73);
        legal = ld | st | br | jal | jalr | lui | auipc | opimm | opr | nop;
        imm   = (opimm | ld | jalr) ? 3'd1 : st ? 3'd2 : br ? 3'd3 :
                (lui | auipc) ? 3'd4 : jal ? 3'd5 : 3'd0;
        for (int k = 0; k < fw && k < Tmo; k++) begin
            c = '0;
            c.imem_req = 1'b1;
            add(c, 1'b0, 1'b1);
        end
        if (fw >= Tmo) begin
            add_trap();
            return;
        end
        c = '0;
        c.imem_req = 1'b1;
        c.ir_write = 1'b1;
        add(c, 1'b1, 1'b1);
        c = '0;
        c.imm = imm;
        c.pc_write = nop;
        add(c, 1'b1, 1'b1);
        if (nop) return;
        if (!legal) begin
            add_trap();
            return;
        end
        c = '0;
        c.imm   = imm;
        c.a_pc  = auipc | jal | br;
        c.b_imm = ~opr;
        if (br) begin
            c.pc_write = 1'b1;
            c.pc_sel   = taken;
        end
        add(c, 1'b1, 1'b1);
        if (br) return;
        if (ld || st) begin
            for (int k = 0; k < mw && k < Tmo; k++) begin
                c = '0;
                c.imm      = imm;
                c.dmem_req = 1'b1;
                c.dmem_we  = st;
                add(c, 1'b1, 1'b0);
            end
            if (mw >= Tmo) begin
                add_trap();
                return;
            end
            c = '0;
            c.imm      = imm;
            c.dmem_req = 1'b1;
            c.dmem_we  = st;
            c.pc_write = st;
            add(c, 1'b1, 1'b1);
            if (st) return;
        end
        c = '0;
        c.imm       = imm;
        c.reg_write = (ins[11:7] != 5'd0);
        c.wb        = ld ? 2'b01 : (jal | jalr) ? 2'b10 : 2'b00;
        c.pc_write  = 1'b1;
        c.pc_sel    = jal | jalr;
        add(c, 1'b1, 1'b1);
    endfunction

    function automatic void pin(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endfunction

    task automatic run(input string name, input logic [31:0] ins, input int fw, input int mw,
                       input logic taken, input int limit);
        build(ins, fw, mw, taken);
        for (int i = 0; i < seq_o.size() && i < limit; i++) begin
            @(posedge clock);
            #1;
            reset          = 1'b0;
            cur_name       = name;
            instruction    = ins;
            branch_taken   = taken;
            bus.imem_ready = seq_i[i].iready;
            bus.dmem_ready = seq_i[i].dready;
            exp_q.push_back(seq_o[i]);
            idx_q.push_back(i);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset          = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        cur_name       = "reset";
        exp_q.push_back('0);
        idx_q.push_back(0);
    endtask

    // Single compare process: every cycle with a pending expectation
    always @(negedge clock) begin
        ctl_t act, e;
        int   idx;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            idx = idx_q.pop_front();
            act = {bus.imem_req, ir_write, bus.dmem_req, bus.dmem_we, immediate_select,
                   alu_src_a_pc, alu_src_b_imm, reg_write, wb_select, pc_write, pc_select, trap};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h required %h", cur_name, idx, act, e);
            end
        end
    end

    initial begin
        int n;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        do_reset();

        run("addi_w1", 32'h00500093, 1, 0, 1'b0, 1000);
        pin("addi_w1_len", seq_o.size(), 5);
        pin("addi_w1_regwr_c4", int'(seq_o[4].reg_write), 1);
        run("addi", 32'h00500093, 0, 0, 1'b0, 1000);
        pin("addi_len", seq_o.size(), 4);

        run("sw_w3", 32'h0020A423, 0, 3, 1'b0, 1000);
        n = 0;
        foreach (seq_o[i]) n += int'(seq_o[i].dmem_req);
        pin("sw_w3_dmem_cycles", n, 4);
        run("sw", 32'h0020A423, 0, 0, 1'b0, 1000);
        pin("sw_len", seq_o.size(), 4);

        run("beq_taken", 32'h00000463, 0, 0, 1'b1, 1000);
        pin("beq_len", seq_o.size(), 3);
        run("beq_not", 32'h00000463, 2, 0, 1'b0, 1000);

        run("jal", 32'h010000EF, 0, 0, 1'b0, 1000);
        run("lw_x0", 32'h0000A003, 0, 0, 1'b0, 1000);
        pin("lw_len", seq_o.size(), 5);
        pin("lw_x0_noregwr", int'(seq_o[4].reg_write), 0);
        run("lw_x5_w2", 32'h0000A283, 0, 2, 1'b0, 1000);
        run("lui", 32'h000011B7, 0, 0, 1'b0, 1000);
        run("auipc", 32'h00001197, 0, 0, 1'b0, 1000);
        run("jalr", 32'h000100E7, 0, 0, 1'b0, 1000);
        run("add", 32'h002081B3, 0, 0, 1'b0, 1000);
        run("fence", 32'h0000000F, 0, 0, 1'b0, 1000);
        pin("fence_len", seq_o.size(), 2);
        run("ecall", 32'h00000073, 1, 0, 1'b0, 1000);

        run("imem_timeout", 32'h00500093, 100, 0, 1'b0, 1000);
        pin("imem_timeout_trap_c4", int'(seq_o[4].trap), 1);
        do_reset();
        run("illegal", 32'h0000007F, 0, 0, 1'b0, 1000);
        pin("illegal_trap_c2", int'(seq_o[2].trap), 1);
        do_reset();
        run("dmem_timeout", 32'h0000A283, 0, 100, 1'b0, 1000);
        do_reset();

        // Reset lands in the middle of a data wait
        run("lw_cut", 32'h0000A283, 0, 100, 1'b0, 5);
        do_reset();
        run("after_reset", 32'h00500093, 0, 0, 1'b0, 1000);

        @(posedge clock);
        @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
